// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operands and opcode in, registered result, flags and handshake out.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       aluCont;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, aluCont,
        input  result, hi, zero, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, a, b, aluCont,
        output result, hi, zero, carry_out, overflow, busy, done
    );
endinterface

// File: rtl/alu_multicycle.sv
// MIPS execute-stage ALU: single-cycle logic/add/sub/slt plus a WIDTH-cycle unsigned shift-add MULTU.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    alu_multicycle_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_MULT = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state, state_nxt;
    op_e              op;
    logic             accept, last;
    logic [CW-1:0]    step;
    logic [WIDTH-1:0] mcand, mq, acc;
    logic [WIDTH:0]   mac_sum;
    logic [WIDTH-1:0] acc_nxt, mq_nxt;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff, add_s;
    logic             add_c, add_v;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    logic [WIDTH-1:0] result_q, hi_q;
    logic             zero_q, carry_q, ovf_q, done_q;

    assign op     = op_e'(bus.aluCont);
    assign accept = (state == S_IDLE) && bus.start;
    assign last   = (step == CW'(WIDTH - 1));

    // One multiplier bit per step: conditionally add, then shift {acc,mq} right.
    assign mac_sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    assign acc_nxt = mac_sum[WIDTH:1];
    assign mq_nxt  = {mac_sum[0], mq[WIDTH-1:1]};

    // Shared adder: SUB/SLT invert B and inject carry-in 1.
    assign is_sub         = (op == OP_SUB) || (op == OP_SLT);
    assign b_eff          = is_sub ? ~bus.b : bus.b;
    assign {add_c, add_s} = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign add_v          = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_ADD, OP_SUB: begin
                alu_res = add_s;
                alu_c   = add_c;
                alu_v   = add_v;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1] ^ add_v};
                alu_c   = add_c;
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && op == OP_MULT) state_nxt = S_MUL;
            S_MUL:   if (last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand    <= '0;
            mq       <= '0;
            acc      <= '0;
            step     <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (op == OP_MULT) begin
                    mcand <= bus.a;
                    mq    <= bus.b;
                    acc   <= '0;
                    step  <= '0;
                end else begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    carry_q  <= alu_c;
                    ovf_q    <= alu_v;
                    done_q   <= 1'b1;
                end
            end else if (state == S_MUL) begin
                acc  <= acc_nxt;
                mq   <= mq_nxt;
                step <= step + 1'b1;
                if (last) begin
                    result_q <= mq_nxt;
                    hi_q     <= acc_nxt;
                    zero_q   <= ({acc_nxt, mq_nxt} == '0);
                    carry_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = zero_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state == S_MUL);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table for single-cycle ops plus MULTU timing, abort and back-to-back sequences.
module tb_alu_multicycle;
    localparam int W  = 32;
    localparam int NV = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vt[NV];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.aluCont = 3'b011;
        bus.a       = x;
        bus.b       = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_cycles;
        int hold_err;

        vt[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{3'b110, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{3'b000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{3'b001, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{3'b100, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{3'b101, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0};
        vt[10] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0};
        vt[11] = '{3'b111, 32'h00000003, 32'h00000002, 32'h00000000, 1'b1, 1'b1, 1'b0};

        // Reset held two cycles with a pending ADD request.
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.aluCont = 3'b010;
        bus.a       = 32'd1;
        bus.b       = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst result", bus.result, 0);
        chk("rst hi", bus.hi, 0);
        chk("rst flags", {bus.zero, bus.carry_out, bus.overflow}, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;

        // Single-cycle vectors issued back to back with start held high.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.start   = 1'b1;
            bus.aluCont = vt[i].op;
            bus.a       = vt[i].a;
            bus.b       = vt[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d result", i), bus.result, vt[i].res);
            chk($sformatf("v%0d zero", i), bus.zero, vt[i].z);
            chk($sformatf("v%0d carry", i), bus.carry_out, vt[i].c);
            chk($sformatf("v%0d overflow", i), bus.overflow, vt[i].v);
            chk($sformatf("v%0d done", i), bus.done, 1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("done drops", bus.done, 0);
        chk("hi untouched", bus.hi, 0);

        // MULTU max*max, with an ADD request held through busy.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.aluCont = 3'b011;
        bus.a       = 32'hFFFFFFFF;
        bus.b       = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        chk("mul busy rise", bus.busy, 1);
        bus.aluCont = 3'b010;
        bus.a       = 32'd1;
        bus.b       = 32'd2;
        busy_cycles = 0;
        hold_err    = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_cycles++;
            if (bus.done || bus.result !== vt[NV-1].res || bus.hi !== 32'h0) hold_err++;
        end
        chk("mul busy cycles", busy_cycles, 32);
        chk("mul outputs held", hold_err, 0);
        chk("mul done", bus.done, 1);
        chk("mul result", bus.result, 32'h00000001);
        chk("mul hi", bus.hi, 32'hFFFFFFFE);
        chk("mul flags", {bus.zero, bus.carry_out, bus.overflow}, 0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("mul done width", bus.done, 0);
        chk("ignored add", bus.result, 32'h00000001);

        @(negedge clk);
        bus.start   = 1'b1;
        bus.aluCont = 3'b010;
        bus.a       = 32'd1;
        bus.b       = 32'd2;
        @(posedge clk);
        #1;
        chk("add after mul", bus.result, 3);
        chk("hi kept", bus.hi, 32'hFFFFFFFE);
        @(negedge clk);
        bus.start = 1'b0;

        // Reset at step 10 of a multiply.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.aluCont = 3'b011;
        bus.a       = 32'h00001234;
        bus.b       = 32'h00005678;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort result", bus.result, 0);
        chk("abort hi", bus.hi, 0);
        chk("abort flags", {bus.zero, bus.carry_out, bus.overflow}, 0);
        chk("abort done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort no done", bus.done, 0);

        mul_run(32'd6, 32'd7, lat);
        chk("6x7 latency", lat, 32);
        chk("6x7 result", bus.result, 42);
        chk("6x7 hi", bus.hi, 0);
        chk("6x7 zero", bus.zero, 0);

        // ADD issued in the MULTU done cycle.
        mul_run(32'h00010000, 32'h00030000, lat);
        chk("b2b mul result", bus.result, 0);
        chk("b2b mul hi", bus.hi, 3);
        chk("b2b mul zero", bus.zero, 0);
        bus.start   = 1'b1;
        bus.aluCont = 3'b010;
        bus.a       = 32'd1;
        bus.b       = 32'd2;
        @(posedge clk);
        #1;
        chk("b2b add result", bus.result, 3);
        chk("b2b add done", bus.done, 1);
        chk("b2b hi kept", bus.hi, 3);
        @(negedge clk);
        bus.start = 1'b0;

        mul_run(32'd0, 32'd5, lat);
        chk("zero prod flag", bus.zero, 1);
        chk("zero prod hi", bus.hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
